instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 74 +++++++
 tb/tb_instr_encoder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Instruction encoder: packs decoded fields into 32-bit words and buffers them
// in a small FIFO ahead of the decode stage.
module instr_encoder #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  aluop,
    input  logic [4:0]  ws,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr_out,
    output logic        err_trunc,
    output logic [15:0] issued
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          accept, pop;
    logic          imm_fmt;
    logic [31:0]   word;

    assign in_ready  = (count < FULL);
    assign out_valid = (count != '0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign imm_fmt   = aluop[3];

    // Immediate format drops rs2 and keeps only the low half of imm.
    always_comb begin
        word = {aluop, ws, rs1, rs2, 11'b0};
        if (imm_fmt)
            word = {aluop, ws, rs1, imm[15:0]};
    end

    assign instr_out = out_valid ? mem[rd_ptr] : 32'h0;

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            err_trunc <= 1'b0;
            issued    <= 16'h0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                issued <= issued + 16'h1;
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            err_trunc <= accept && imm_fmt && (imm[31:16] != 16'h0);
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding table plus full/drain and reset corners.
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  aluop;
    logic [4:0]  ws, rs1, rs2;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr_out;
    logic        err_trunc;
    logic [15:0] issued;

    int checks = 0;
    int errors = 0;

    instr_encoder #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .ws(ws), .rs1(rs1), .rs2(rs2), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .instr_out(instr_out),
        .err_trunc(err_trunc), .issued(issued)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  aluop;
        logic [4:0]  ws, rs1, rs2;
        logic [31:0] imm;
        logic [31:0] exp_word;
        logic        exp_trunc;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] expq [$];
        int          acc;
        int          first_pop;
        int          popped;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        aluop = '0; ws = '0; rs1 = '0; rs2 = '0; imm = '0;

        vecs[0] = '{6'h02,  5'd3,  5'd1, 5'd2,  32'h0000_0000, 32'h0861_1000, 1'b0};
        vecs[1] = '{6'h08,  5'd5,  5'd4, 5'd7,  32'h0000_1234, 32'h20A4_1234, 1'b0};
        vecs[2] = '{6'h08,  5'd0,  5'd0, 5'd0,  32'h0001_0005, 32'h2000_0005, 1'b1};
        vecs[3] = '{6'h01,  5'd31, 5'd0, 5'd31, 32'hFFFF_FFFF, 32'h07E0_F800, 1'b0};
        vecs[4] = '{6'h3F,  5'd1,  5'd2, 5'd3,  32'hFFFF_0000, 32'hFC22_0000, 1'b1};

        do_reset();
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset in_ready",  32'(in_ready),  32'd1);
        chk("reset instr_out", instr_out,      32'h0);
        chk("reset issued",    32'(issued),    32'd0);
        chk("reset err_trunc", 32'(err_trunc), 32'd0);

        // No bypass: the word being accepted is not visible in the same cycle.
        aluop = vecs[0].aluop; ws = vecs[0].ws; rs1 = vecs[0].rs1; rs2 = vecs[0].rs2;
        imm = vecs[0].imm; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("no bypass out_valid", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        chk("latency out_valid", 32'(out_valid), 32'd1);
        chk("latency instr_out", instr_out, 32'h0861_1000);
        tick();
        out_ready = 1'b0;
        chk("latency issued", 32'(issued), 32'd1);
        do_reset();

        // Encoding table: accept one word, check it at the head, then pop it.
        foreach (vecs[i]) begin
            aluop = vecs[i].aluop; ws = vecs[i].ws; rs1 = vecs[i].rs1;
            rs2 = vecs[i].rs2; imm = vecs[i].imm;
            in_valid = 1'b1; out_ready = 1'b0;
            tick();
            in_valid = 1'b0;
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d instr_out", i), instr_out, vecs[i].exp_word);
            chk($sformatf("vec%0d err_trunc", i), 32'(err_trunc), 32'(vecs[i].exp_trunc));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk($sformatf("vec%0d issued", i), 32'(issued), 32'(i + 1));
            chk($sformatf("vec%0d trunc pulse end", i), 32'(err_trunc), 32'd0);
            chk($sformatf("vec%0d empty", i), 32'(out_valid), 32'd0);
        end

        // Full/drain: five back-to-back offers against a stalled consumer.
        do_reset();
        acc = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            aluop = 6'h08; ws = '0; rs1 = '0; rs2 = '0; imm = 32'(k + 1);
            in_valid = 1'b1;
            tick();
        end
        chk("full in_ready", 32'(in_ready), 32'd0);
        chk("full head", instr_out, 32'h2000_0001);
        // Fifth word (imm=5) is still being offered; drain and let it in.
        out_ready = 1'b1;
        first_pop = -1;
        popped = 0;
        for (int k = 1; k <= 5; k++) expq.push_back(32'h2000_0000 | 32'(k));
        for (int cyc = 0; cyc < 20 && popped < 5; cyc++) begin
            if (out_valid) begin
                chk($sformatf("drain word%0d", popped), instr_out, expq[popped]);
                popped++;
            end
            if (in_valid && in_ready) acc++;
            tick();
            if (acc == 1) in_valid = 1'b0;
            if (first_pop < 0) begin
                first_pop = cyc;
                chk("in_ready after first pop", 32'(in_ready), 32'd1);
            end
        end
        chk("drain count", 32'(popped), 32'd5);
        chk("drain issued", 32'(issued), 32'd5);
        chk("drain empty", 32'(out_valid), 32'd0);
        in_valid = 1'b0; out_ready = 1'b0;

        // Reset mid-operation with accept and pop both requested.
        for (int k = 0; k < 2; k++) begin
            aluop = 6'h02; ws = 5'(k); rs1 = '0; rs2 = '0; imm = '0;
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("pre-reset out_valid", 32'(out_valid), 32'd1);
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("midreset out_valid", 32'(out_valid), 32'd0);
        chk("midreset issued",    32'(issued),    32'd0);
        chk("midreset instr_out", instr_out,      32'h0);
        chk("midreset in_ready",  32'(in_ready),  32'd1);
        tick();
        chk("midreset nothing enqueued", 32'(out_valid), 32'd0);
        chk("midreset issued hold",      32'(issued),    32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
